spi_tx_arbiter: RTL and testbench

//  Shares one SPI byte-transmit master among NREQ requesters.

---
 rtl/spi_pkg.sv | 15 +
 rtl/spi_rr_pick.sv | 29 ++
 rtl/spi_tx_arbiter.sv | 126 ++++++++++++
 tb/tb_spi_tx_arbiter.sv | 349 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// rtl/spi_pkg.sv - shared state encoding and defaults for the SPI transmit arbiter
package spi_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    LAUNCH   = 2'd1,
    WAIT_END = 2'd2,
    DONE     = 2'd3
  } arb_state_t;

  localparam int NREQ_DEF = 4;
  localparam int DW_DEF   = 8;
  localparam int WD_MIN_W = 8;

endpackage

// File: rtl/spi_rr_pick.sv
// rtl/spi_rr_pick.sv - combinational rotating-priority picker; ptr holds the highest priority
module spi_rr_pick
  import spi_pkg::*;
#(
  parameter int NREQ = NREQ_DEF,
  parameter int IW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   ptr,
  output logic [IW-1:0]   idx,
  output logic            any
);

  logic [IW-1:0] cand;

  // Walk from the lowest priority up so the slot at ptr is written last and wins.
  always_comb begin
    idx  = '0;
    cand = '0;
    any  = |req;
    for (int k = NREQ - 1; k >= 0; k--) begin
      cand = IW'((int'(ptr) + k) % NREQ);
      if (req[cand]) begin
        idx = cand;
      end
    end
  end

endmodule

// File: rtl/spi_tx_arbiter.sv
// rtl/spi_tx_arbiter.sv - round-robin arbiter sharing one SPI byte-transmit master
// SPI_ARB_TIMEOUT_EN adds a watchdog that aborts a stalled transfer and pulses err.
module spi_tx_arbiter
  import spi_pkg::*;
#(
  parameter int NREQ      = NREQ_DEF,
  parameter int DW        = DW_DEF,
  parameter int TO_CYCLES = 255
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NREQ-1:0]    req,
  input  logic [NREQ*DW-1:0] req_dat,
  output logic [NREQ-1:0]    gnt,
  output logic [NREQ-1:0]    done,
  output logic               spi_tx_en,
  output logic [DW-1:0]      spi_dat,
  input  logic               spi_cs,
  output logic               busy,
  output logic               err
);

  localparam int IW = $clog2(NREQ);
  localparam logic [NREQ-1:0] ONE = NREQ'(1);

  arb_state_t    state, state_n;
  logic [IW-1:0] ptr, ptr_n;
  logic [IW-1:0] idx_q, idx_n;
  logic [IW-1:0] ptr_adv;
  logic [IW-1:0] pick_idx;
  logic          pick_any;
  logic [DW-1:0] dat_n;
  logic [DW-1:0] req_slot [NREQ];

  for (genvar i = 0; i < NREQ; i++) begin : g_slot
    assign req_slot[i] = req_dat[i*DW +: DW];
  end

  spi_rr_pick #(
    .NREQ (NREQ),
    .IW   (IW)
  ) u_pick (
    .req (req),
    .ptr (ptr),
    .idx (pick_idx),
    .any (pick_any)
  );

  // The requester just served drops to the lowest priority.
  assign ptr_adv = (idx_q == IW'(NREQ - 1)) ? '0 : idx_q + IW'(1);

  assign busy      = (state != IDLE);
  assign spi_tx_en = (state == LAUNCH);
  assign gnt       = busy ? (ONE << idx_q) : '0;
  assign done      = (state == DONE) ? (ONE << idx_q) : '0;

`ifdef SPI_ARB_TIMEOUT_EN
  localparam int CW = ($clog2(TO_CYCLES + 1) > WD_MIN_W) ? $clog2(TO_CYCLES + 1) : WD_MIN_W;

  logic [CW-1:0] wd_cnt;
  logic          to_hit;
  logic          err_q;

  assign to_hit = ((state == LAUNCH) || (state == WAIT_END)) && (wd_cnt == CW'(TO_CYCLES - 1));
  assign err    = err_q;

  always_ff @(posedge clk) begin
    if (rst || (state == IDLE)) begin
      wd_cnt <= '0;
    end else if (state != DONE) begin
      wd_cnt <= wd_cnt + CW'(1);
    end
    err_q <= rst ? 1'b0 : to_hit;
  end
`else
  assign err = 1'b0;
`endif

  always_comb begin
    state_n = state;
    ptr_n   = ptr;
    idx_n   = idx_q;
    dat_n   = spi_dat;
    case (state)
      IDLE: begin
        if (pick_any) begin
          state_n = LAUNCH;
          idx_n   = pick_idx;
          dat_n   = req_slot[pick_idx];
        end
      end
      LAUNCH: begin
        if (!spi_cs) state_n = WAIT_END;
      end
      WAIT_END: begin
        if (spi_cs) state_n = DONE;
      end
      DONE: begin
        state_n = IDLE;
        ptr_n   = ptr_adv;
      end
      default: state_n = IDLE;
    endcase
`ifdef SPI_ARB_TIMEOUT_EN
    if (to_hit) begin
      state_n = IDLE;
      ptr_n   = ptr_adv;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      ptr     <= '0;
      idx_q   <= '0;
      spi_dat <= '0;
    end else begin
      state   <= state_n;
      ptr     <= ptr_n;
      idx_q   <= idx_n;
      spi_dat <= dat_n;
    end
  end

endmodule

// File: tb/tb_spi_tx_arbiter.sv
// tb/tb_spi_tx_arbiter.sv - self-checking bench for spi_tx_arbiter with a simple SPI master cs model
module tb_spi_tx_arbiter;

  localparam int NREQ = 4;
  localparam int DW   = 8;
  localparam int TO   = 20;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [3:0]      req = '0;
  logic [31:0]     req_dat = '0;
  logic            spi_cs = 1'b1;
  logic [3:0]      gnt;
  logic [3:0]      done;
  logic            spi_tx_en;
  logic [7:0]      spi_dat;
  logic            busy;
  logic            err;

  spi_tx_arbiter #(
    .NREQ      (NREQ),
    .DW        (DW),
    .TO_CYCLES (TO)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .req_dat   (req_dat),
    .gnt       (gnt),
    .done      (done),
    .spi_tx_en (spi_tx_en),
    .spi_dat   (spi_dat),
    .spi_cs    (spi_cs),
    .busy      (busy),
    .err       (err)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic int oh2i(input logic [3:0] v);
    for (int i = 0; i < 4; i++) if (v[i]) return i;
    return -1;
  endfunction

  function automatic int qat(input int q[$], input int i);
    return (i < q.size()) ? q[i] : -1;
  endfunction

  // SPI master stand-in: cs falls 2 cycles after tx_en is seen, rises cs_low_len cycles later.
  int cs_low_len = 6;
  int cs_lag_left = 0;
  int cs_low_left = 0;
  bit cs_active = 0;
  bit cs_stuck = 0;

  initial forever begin
    @(negedge clk);
    if (rst) begin
      spi_cs = 1'b1;
      cs_active = 0;
    end else if (!cs_stuck) begin
      if (!cs_active) begin
        if (spi_tx_en) begin
          cs_active = 1;
          cs_lag_left = 2;
        end
      end else if (cs_lag_left > 0) begin
        cs_lag_left--;
        if (cs_lag_left == 0) begin
          spi_cs = 1'b0;
          cs_low_left = cs_low_len;
        end
      end else begin
        cs_low_left--;
        if (cs_low_left == 0) begin
          spi_cs = 1'b1;
          cs_active = 0;
        end
      end
    end
  end

  // Transaction-level reference: who owns the master, whether cs has been seen low,
  // and whether this is the completion cycle.
  int        m_owner = -1;
  int        m_ptr = 0;
  int        m_age = 0;
  bit        m_launched = 0;
  bit        m_fin = 0;
  bit        m_err = 0;
  bit        m_found = 0;
  bit        m_abort = 0;
  logic [7:0] m_byte = '0;

  initial forever begin
    @(posedge clk);
    m_err = 0;
    m_abort = 0;
    if (rst) begin
      m_owner = -1; m_ptr = 0; m_age = 0; m_launched = 0; m_fin = 0; m_byte = '0;
    end else if (m_fin) begin
      m_ptr = (m_owner + 1) % NREQ;
      m_owner = -1;
      m_fin = 0;
    end else if (m_owner < 0) begin
      m_found = 0;
      for (int k = 0; k < NREQ; k++) begin
        if (!m_found && req[(m_ptr + k) % NREQ]) begin
          m_found = 1;
          m_owner = (m_ptr + k) % NREQ;
          m_byte = req_dat[m_owner*8 +: 8];
          m_launched = 0;
          m_age = 0;
        end
      end
    end else begin
`ifdef SPI_ARB_TIMEOUT_EN
      if (m_age == TO - 1) begin
        m_abort = 1;
        m_err = 1;
        m_ptr = (m_owner + 1) % NREQ;
        m_owner = -1;
      end else begin
        m_age++;
      end
`endif
      if (!m_abort) begin
        if (!m_launched) begin
          if (!spi_cs) m_launched = 1;
        end else if (spi_cs) begin
          m_fin = 1;
        end
      end
    end
  end

  int        gq[$];
  int        dq[$];
  int        doneq[$];
  int        err_n = 0;
  logic [3:0] prev_gnt = '0;

  initial forever begin
    @(negedge clk);
    chk("gnt",   gnt,       (m_owner >= 0) ? (32'd1 << m_owner) : 32'd0);
    chk("done",  done,      m_fin ? (32'd1 << m_owner) : 32'd0);
    chk("tx_en", spi_tx_en, (m_owner >= 0 && !m_launched) ? 32'd1 : 32'd0);
    chk("busy",  busy,      (m_owner >= 0) ? 32'd1 : 32'd0);
    chk("dat",   spi_dat,   m_byte);
    chk("err",   err,       m_err);
    if (gnt != 0 && prev_gnt == 0) begin
      gq.push_back(oh2i(gnt));
      dq.push_back(int'(spi_dat));
    end
    if (done != 0) doneq.push_back(oh2i(done));
    if (err) err_n++;
    prev_gnt = gnt;
  end

  bit auto_drop = 0;

  task automatic tick();
    @(negedge clk);
    #1;
    if (auto_drop) req = req & ~done;
  endtask

  task automatic clear_logs();
    gq.delete(); dq.delete(); doneq.delete(); err_n = 0;
  endtask

  task automatic pulse_rst();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    clear_logs();
  endtask

  task automatic wait_grants(input int n, input int budget);
    int c = 0;
    while (gq.size() < n && c < budget) begin
      tick();
      c++;
    end
    chk("wait_grant", gq.size() >= n, 1);
  endtask

  task automatic wait_dones(input int n, input int budget);
    int c = 0;
    while (doneq.size() < n && c < budget) begin
      tick();
      c++;
    end
    chk("wait_done", doneq.size() >= n, 1);
  endtask

  initial begin
    int c;
    rst = 1'b1;
    repeat (3) tick();
    chk("rst_gnt", gnt, 0);
    chk("rst_done", done, 0);
    chk("rst_txen", spi_tx_en, 0);
    chk("rst_dat", spi_dat, 0);
    chk("rst_busy", busy, 0);
    chk("rst_err", err, 0);
    rst = 1'b0;
    clear_logs();

    // single requester, long cs-low window
    cs_low_len = 80;
    req_dat[7:0] = 8'hA5;
    req = 4'b0001;
    wait_grants(1, 10);
    chk("t1_gnt", gnt, 4'b0001);
    chk("t1_dat", spi_dat, 8'hA5);
    chk("t1_txen", spi_tx_en, 1);
    req = 4'b0000;
    wait_dones(1, 200);
    chk("t1_done", done, 4'b0001);
    chk("t1_busy_done", busy, 1);
    tick();
    chk("t1_busy_after", busy, 0);
    chk("t1_done_after", done, 0);
    repeat (5) tick();
    chk("t1_done_count", doneq.size(), 1);

    // two simultaneous requests from reset
    pulse_rst();
    cs_low_len = 6;
    req_dat = 32'h0022_1100;
    auto_drop = 1;
    req = 4'b0110;
    wait_dones(2, 200);
    repeat (3) tick();
    chk("t2_g0", qat(gq, 0), 1);
    chk("t2_g1", qat(gq, 1), 2);
    chk("t2_ngrant", gq.size(), 2);
    chk("t2_d0", qat(doneq, 0), 1);
    chk("t2_d1", qat(doneq, 1), 2);

    // all requests held: full rotation plus wrap
    pulse_rst();
    auto_drop = 0;
    req_dat = 32'h4433_2211;
    req = 4'b1111;
    wait_dones(5, 400);
    req = 4'b0000;
    repeat (4) tick();
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("t3_order%0d", i), qat(gq, i), i % 4);
      chk($sformatf("t3_dat%0d", i), qat(dq, i), (i % 4 + 1) * 32'h11);
    end
    chk("t3_ndone", doneq.size(), 5);

    // requester drops req and changes its byte after the grant
    clear_logs();
    req_dat = '0;
    req_dat[23:16] = 8'h3C;
    req = 4'b0100;
    wait_grants(1, 10);
    req = 4'b0000;
    req_dat[23:16] = 8'hC3;
    wait_dones(1, 100);
    tick();
    chk("t4_latched", qat(dq, 0), 8'h3C);
    chk("t4_done", qat(doneq, 0), 2);
    chk("t4_dat_hold", spi_dat, 8'h3C);

    // reset during WAIT_END; requester 0 must win afterwards
    clear_logs();
    cs_low_len = 40;
    req_dat[15:8] = 8'h77;
    req = 4'b0010;
    wait_grants(1, 10);
    req = 4'b0000;
    c = 0;
    while (!(gnt != 0 && !spi_tx_en) && c < 20) begin
      tick();
      c++;
    end
    chk("t5_reach_wait", (gnt != 0 && !spi_tx_en), 1);
    rst = 1'b1;
    req_dat = 32'hA300_005A;
    req = 4'b1001;
    tick();
    chk("t5_gnt", gnt, 0);
    chk("t5_done", done, 0);
    chk("t5_busy", busy, 0);
    chk("t5_txen", spi_tx_en, 0);
    chk("t5_dat", spi_dat, 0);
    chk("t5_nodone", doneq.size(), 0);
    rst = 1'b0;
    clear_logs();
    cs_low_len = 6;
    auto_drop = 1;
    wait_grants(1, 10);
    chk("t5_first", qat(gq, 0), 0);
    chk("t5_first_dat", spi_dat, 8'h5A);
    wait_dones(2, 200);
    chk("t5_second", qat(doneq, 1), 3);
    req = 4'b0000;
    repeat (3) tick();

`ifdef SPI_ARB_TIMEOUT_EN
    // stalled master: watchdog aborts requester 0, requester 1 goes next
    pulse_rst();
    cs_stuck = 1;
    req = 4'b0011;
    wait_grants(1, 10);
    c = 0;
    while (err_n == 0 && c < 40) begin
      tick();
      c++;
    end
    chk("t6_err_lat", c, TO);
    cs_stuck = 0;
    wait_dones(1, 100);
    req = 4'b0000;
    repeat (3) tick();
    chk("t6_g0", qat(gq, 0), 0);
    chk("t6_g1", qat(gq, 1), 1);
    chk("t6_d0", qat(doneq, 0), 1);
    chk("t6_ndone", doneq.size(), 1);
    chk("t6_nerr", err_n, 1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running, expected finished");
    $fatal(1);
  end

endmodule
